// File: rtl/conv_requant.sv
// conv_requant: CFU-style requantization unit. It holds the per-layer parameters
// (bias, fixed-point multiplier, shift, output offset, activation range) and runs
// accumulator values through bias -> rounding doubling high multiply -> rounding
// right shift -> offset and clamp, one stage per cycle.
//
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_payload_function_id    [9:3] func7 opcode, [2:0] ignored
//   cmd_payload_inputs_0/1     operands A and B
//   rsp_valid / rsp_ready      response handshake
//   rsp_payload_outputs_0      response data
//
// Opcodes (func7): 0 defaults, 1 bias, 2 multiplier/shift, 3 output offset,
// 4 activation range, 5 requantize A, 6 read-and-clear saturation count.
//
// Optional feature: define REQUANT_SAT_COUNT_EN to add a SAT_CNT_W-bit saturating
// counter of clamped results, readable (and cleared) by opcode 6. Without it,
// opcode 6 behaves as an unknown opcode and returns 0.
module conv_requant #(
  parameter int unsigned SAT_CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  typedef enum logic [2:0] {StIdle, StBias, StMul, StShift, StClamp} state_e;

  localparam logic signed [31:0] DefMult   = 32'sh4000_0000;
  localparam logic signed [31:0] DefActMin = -32'sd128;
  localparam logic signed [31:0] DefActMax = 32'sd127;
  localparam logic signed [31:0] MinInt    = 32'sh8000_0000;
  localparam logic signed [31:0] MaxInt    = 32'sh7FFF_FFFF;

  state_e             state_q, state_d;
  logic signed [31:0] data_q, data_d;
  logic signed [31:0] bias_q, bias_d, mult_q, mult_d, shift_q, shift_d;
  logic signed [31:0] offset_q, offset_d, act_min_q, act_min_d, act_max_q, act_max_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;

  logic [6:0] func7;
  logic       cmd_fire;

  assign func7     = cmd_payload_function_id[9:3];
  assign cmd_ready = !rsp_valid_q && (state_q == StIdle);
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;

  // Bias stage: add bias, then left shift for positive shift (bits beyond 31 all fall off).
  logic signed [31:0] biased, bias_out;
  always_comb begin
    biased = data_q + bias_q;
    if (shift_q <= 0) begin
      bias_out = biased;
    end else if (shift_q > 31) begin
      bias_out = '0;
    end else begin
      bias_out = biased << shift_q[4:0];
    end
  end

  // Multiply stage: saturating rounding doubling high multiply.
  logic signed [63:0] prod, nudged, quot;
  logic signed [31:0] mul_out;
  always_comb begin
    prod   = {{32{data_q[31]}}, data_q} * {{32{mult_q[31]}}, mult_q};
    nudged = prod + ((prod >= 0) ? 64'sd1073741824 : -64'sd1073741823);
    // Bias negative values by 2^31-1 so the arithmetic shift truncates toward zero.
    quot   = (nudged < 0) ? ((nudged + 64'sd2147483647) >>> 31) : (nudged >>> 31);
    if (data_q == MinInt && mult_q == MinInt) begin
      mul_out = MaxInt;
    end else begin
      mul_out = quot[31:0];
    end
  end

  // Shift stage: rounding arithmetic right shift; magnitudes past 31 are held at 31.
  logic [31:0]        neg_shift, mask, threshold;
  logic [4:0]         rs;
  logic signed [31:0] arith, shift_out;
  always_comb begin
    neg_shift = -shift_q;
    if (!shift_q[31]) begin
      rs = 5'd0;
    end else if (neg_shift > 32'd31) begin
      rs = 5'd31;
    end else begin
      rs = neg_shift[4:0];
    end
    mask      = (32'd1 << rs) - 32'd1;
    threshold = (mask >> 1) + {31'd0, data_q[31]};
    arith     = data_q >>> rs;
    shift_out = arith + (((data_q & mask) > threshold) ? 32'sd1 : 32'sd0);
  end

  // Clamp stage: an inverted range resolves to act_max since max is applied last.
  logic signed [31:0] offs, lo_clip, clamp_out;
  always_comb begin
    offs      = data_q + offset_q;
    lo_clip   = (offs < act_min_q) ? act_min_q : offs;
    clamp_out = (lo_clip > act_max_q) ? act_max_q : lo_clip;
  end

`ifdef REQUANT_SAT_COUNT_EN
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic                 clamped;
  assign clamped = (clamp_out != offs);
`else
  localparam int unsigned UnusedSatCntW = SAT_CNT_W;
`endif

  logic unused_bits;
  assign unused_bits = ^{cmd_payload_function_id[2:0], quot[63:32]};

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    bias_d      = bias_q;
    mult_d      = mult_q;
    shift_d     = shift_q;
    offset_d    = offset_q;
    act_min_d   = act_min_q;
    act_max_d   = act_max_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef REQUANT_SAT_COUNT_EN
    sat_cnt_d   = sat_cnt_q;
`endif

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          if (func7 == 7'd5) begin
            data_d  = cmd_payload_inputs_0;
            state_d = StBias;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            case (func7)
              7'd0: begin
                bias_d    = '0;
                mult_d    = DefMult;
                shift_d   = '0;
                offset_d  = '0;
                act_min_d = DefActMin;
                act_max_d = DefActMax;
              end
              7'd1: bias_d = cmd_payload_inputs_0;
              7'd2: begin
                mult_d  = cmd_payload_inputs_0;
                shift_d = cmd_payload_inputs_1;
              end
              7'd3: offset_d = cmd_payload_inputs_0;
              7'd4: begin
                act_min_d = cmd_payload_inputs_0;
                act_max_d = cmd_payload_inputs_1;
              end
`ifdef REQUANT_SAT_COUNT_EN
              7'd6: begin
                rsp_data_d = 32'(sat_cnt_q);
                sat_cnt_d  = '0;
              end
`endif
              default: ;
            endcase
          end
        end
      end
      StBias: begin
        data_d  = bias_out;
        state_d = StMul;
      end
      StMul: begin
        data_d  = mul_out;
        state_d = StShift;
      end
      StShift: begin
        data_d  = shift_out;
        state_d = StClamp;
      end
      StClamp: begin
        rsp_data_d  = clamp_out;
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
`ifdef REQUANT_SAT_COUNT_EN
        if (clamped && (sat_cnt_q != '1)) begin
          sat_cnt_d = sat_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      data_q      <= '0;
      bias_q      <= '0;
      mult_q      <= DefMult;
      shift_q     <= '0;
      offset_q    <= '0;
      act_min_q   <= DefActMin;
      act_max_q   <= DefActMax;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      bias_q      <= bias_d;
      mult_q      <= mult_d;
      shift_q     <= shift_d;
      offset_q    <= offset_d;
      act_min_q   <= act_min_d;
      act_max_q   <= act_max_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef REQUANT_SAT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_conv_requant.sv
// Self-checking bench for conv_requant: directed cases plus randomized command
// streams compared against an arithmetic reference model.
module tb_conv_requant;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  conv_requant #(.SAT_CNT_W(16)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0   (cmd_payload_inputs_0),
    .cmd_payload_inputs_1   (cmd_payload_inputs_1),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_payload_outputs_0  (rsp_payload_outputs_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state.
  int m_bias, m_mult, m_shift, m_off, m_min, m_max, m_sat;

  task automatic model_defaults();
    m_bias  = 0;
    m_mult  = 32'h4000_0000;
    m_shift = 0;
    m_off   = 0;
    m_min   = -128;
    m_max   = 127;
  endtask

  function automatic int ref_requant(input int acc, output bit clamped);
    int x, y, r, z, o, rs;
    longint p, nud, mask, thr;
    x = acc + m_bias;
    if (m_shift > 0) x = x << m_shift;
    if (x == int'(32'h8000_0000) && m_mult == int'(32'h8000_0000)) begin
      y = 32'h7FFF_FFFF;
    end else begin
      p   = longint'(x) * longint'(m_mult);
      nud = (p >= 0) ? (64'sd1 << 30) : (64'sd1 - (64'sd1 << 30));
      y   = int'((p + nud) / (64'sd1 << 31));
    end
    rs = (m_shift < 0) ? -m_shift : 0;
    if (rs == 0) begin
      r = y;
    end else begin
      mask = (64'sd1 << rs) - 1;
      thr  = (mask >> 1) + ((y < 0) ? 1 : 0);
      r    = (y >>> rs) + (((longint'(y) & mask) > thr) ? 1 : 0);
    end
    z = r + m_off;
    o = (z < m_min) ? m_min : z;
    o = (o > m_max) ? m_max : o;
    clamped = (o != z);
    return o;
  endfunction

  // Issue one command, check latency/data/hold behaviour, then consume the response.
  task automatic run_op(input int f7, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] got);
    logic [31:0] exp;
    int exp_lat, lat, waited;
    bit clamped;
    exp     = '0;
    exp_lat = (f7 == 5) ? 4 : 0;
    case (f7)
      0: model_defaults();
      1: m_bias = a;
      2: begin m_mult = a; m_shift = b; end
      3: m_off = a;
      4: begin m_min = a; m_max = b; end
      5: begin
        exp = ref_requant(a, clamped);
        if (clamped && m_sat < 65535) m_sat++;
      end
`ifdef REQUANT_SAT_COUNT_EN
      6: begin exp = m_sat; m_sat = 0; end
`endif
      default: ;
    endcase

    cmd_valid               = 1'b1;
    cmd_payload_function_id = {7'(f7), 3'($urandom_range(0, 7))};
    cmd_payload_inputs_0    = a;
    cmd_payload_inputs_1    = b;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("cmd_ready idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = rsp_payload_outputs_0;
    check_eq($sformatf("latency f7=%0d", f7), lat, exp_lat);
    check_eq($sformatf("data f7=%0d a=%h", f7, a), got, exp);
    check_eq("cmd_ready busy", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold valid", 32'(rsp_valid), 32'd1);
      check_eq("hold data", rsp_payload_outputs_0, exp);
      check_eq("hold cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("valid drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int f7, a, b, sel, stuck;
    reset                   = 1'b0;
    cmd_valid               = 1'b0;
    rsp_ready               = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0    = '0;
    cmd_payload_inputs_1    = '0;
    model_defaults();
    m_sat = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check_eq("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset payload", rsp_payload_outputs_0, 32'd0);
    check_eq("reset cmd_ready", 32'(cmd_ready), 32'd1);

    // Defaults, in-range and clamped results.
    run_op(5, 32'd100, 32'd0, 0, got);
    check_eq("A=100", got, 32'd50);
    run_op(5, 32'd1000, 32'd0, 0, got);
    check_eq("A=1000", got, 32'd127);
`ifdef REQUANT_SAT_COUNT_EN
    run_op(6, 32'd0, 32'd0, 0, got);
    check_eq("satcnt first", got, 32'd1);
    run_op(6, 32'd0, 32'd0, 0, got);
    check_eq("satcnt second", got, 32'd0);
`else
    run_op(6, 32'd0, 32'd0, 0, got);
    check_eq("op6 unknown", got, 32'd0);
`endif

    // Negative shift rounding.
    run_op(2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, got);
    run_op(5, 32'hFFFF_FFF9, 32'd0, 0, got);
    check_eq("A=-7", got, 32'hFFFF_FFFC);

    // SRDHM saturation corner.
    run_op(2, 32'h8000_0000, 32'd0, 0, got);
    run_op(4, 32'h8000_0000, 32'h7FFF_FFFF, 0, got);
    run_op(5, 32'h8000_0000, 32'd0, 0, got);
    check_eq("min*min", got, 32'h7FFF_FFFF);

    // Back-pressure held for three cycles.
    run_op(0, 32'd0, 32'd0, 0, got);
    run_op(5, 32'd100, 32'd0, 3, got);

    // Inverted activation range resolves to act_max.
    run_op(4, 32'd10, 32'hFFFF_FFF6, 0, got);
    run_op(5, 32'd100, 32'd0, 0, got);
    check_eq("inverted range", got, 32'hFFFF_FFF6);

    // Reset while in the multiply stage.
    run_op(1, 32'd7, 32'd0, 0, got);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {7'd5, 3'd0};
    cmd_payload_inputs_0    = 32'd100;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_defaults();
    m_sat = 0;
    check_eq("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("mid reset payload", rsp_payload_outputs_0, 32'd0);
    stuck = 0;
    repeat (6) begin
      if (rsp_valid) stuck++;
      @(posedge clk); #1;
    end
    check_eq("mid reset no response", stuck, 0);
    run_op(5, 32'd100, 32'd0, 0, got);
    check_eq("after reset A=100", got, 32'd50);

    // Randomized command stream.
    for (int it = 0; it < 400; it++) begin
      sel = int'($urandom_range(0, 11));
      a   = int'($urandom());
      b   = int'($urandom());
      case (sel)
        0: f7 = 0;
        1: begin f7 = 1; if ($urandom_range(0, 1) == 1) a = int'($urandom_range(0, 2000)) - 1000; end
        2: begin
          f7 = 2;
          case ($urandom_range(0, 3))
            0: a = int'(32'h8000_0000);
            1: a = 32'h4000_0000 + int'($urandom_range(0, 65535));
            default: ;
          endcase
          b = int'($urandom_range(0, 62)) - 31;
        end
        3: begin f7 = 3; a = int'($urandom_range(0, 200)) - 100; end
        4: begin
          f7 = 4;
          if ($urandom_range(0, 3) != 0) begin
            a = -int'($urandom_range(0, 300));
            b = int'($urandom_range(0, 300));
          end
        end
        5: f7 = 6;
        6: f7 = 7 + int'($urandom_range(0, 120));
        default: begin
          f7 = 5;
          if ($urandom_range(0, 1) == 1) a = int'($urandom_range(0, 4000)) - 2000;
          if ($urandom_range(0, 15) == 0) a = int'(32'h8000_0000);
        end
      endcase
      run_op(f7, a, b, int'($urandom_range(0, 2)), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
